// File: rtl/plru_cache_ctrl.sv
// Control sequencer for a 4-way set-associative cache with 3-bit tree pseudo-LRU.
// Owns per-set PLRU/valid/dirty state and sequences write-back and line-fill with pmem.
module plru_cache_ctrl #(
    parameter int S_BITS = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [S_BITS-1:0] set_idx,
    input  logic [3:0]        hit,
    output logic [3:0]        valid_out,
    output logic              mem_resp,
    output logic [1:0]        way_sel,
    output logic              data_we,
    output logic              data_sel_fill,
    output logic              tag_we,
    output logic              pmem_addr_sel,
    output logic              pmem_read,
    output logic              pmem_write,
    input  logic              pmem_resp
);
    localparam int NUM_SETS = 1 << S_BITS;

    typedef enum logic [1:0] {IDLE, WB, FILL} state_t;

    state_t            state_q, state_d;
    logic [2:0]        plru_q  [NUM_SETS];
    logic [3:0]        valid_q [NUM_SETS];
    logic [3:0]        dirty_q [NUM_SETS];
    logic [1:0]        victim_q, victim_d;
    logic [S_BITS-1:0] set_q, set_d;

    logic       req, is_wr;
    logic [1:0] hit_w, miss_victim;
    logic       plru_upd, dirty_hit, wb_done, fill_done;

    function automatic logic [1:0] hit_way(input logic [3:0] h);
        if (h[3])      return 2'd3;
        else if (h[2]) return 2'd2;
        else if (h[1]) return 2'd1;
        else           return 2'd0;
    endfunction

    function automatic logic [1:0] pick_victim(input logic [3:0] v, input logic [2:0] p);
        if (!v[0])      return 2'd0;
        else if (!v[1]) return 2'd1;
        else if (!v[2]) return 2'd2;
        else if (!v[3]) return 2'd3;
        else if (!p[2]) return {1'b0, p[1]};
        else            return {1'b1, p[0]};
    endfunction

    // Point every node on the path away from the way just used.
    function automatic logic [2:0] plru_touch(input logic [2:0] p, input logic [1:0] w);
        case (w)
            2'd0:    return {2'b11, p[0]};
            2'd1:    return {2'b10, p[0]};
            2'd2:    return {1'b0, p[1], 1'b1};
            default: return {1'b0, p[1], 1'b0};
        endcase
    endfunction

    assign req         = mem_read | mem_write;
    assign is_wr       = mem_write;
    assign hit_w       = hit_way(hit);
    assign miss_victim = pick_victim(valid_q[set_idx], plru_q[set_idx]);
    assign valid_out   = valid_q[set_idx];

    always_comb begin
        state_d       = state_q;
        victim_d      = victim_q;
        set_d         = set_q;
        mem_resp      = 1'b0;
        way_sel       = 2'd0;
        data_we       = 1'b0;
        data_sel_fill = 1'b0;
        tag_we        = 1'b0;
        pmem_addr_sel = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        plru_upd      = 1'b0;
        dirty_hit     = 1'b0;
        wb_done       = 1'b0;
        fill_done     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req && |hit) begin
                    mem_resp = 1'b1;
                    way_sel  = hit_w;
                    plru_upd = 1'b1;
                    if (is_wr) begin
                        data_we   = 1'b1;
                        dirty_hit = 1'b1;
                    end
                end else if (req) begin
                    victim_d = miss_victim;
                    set_d    = set_idx;
                    state_d  = (valid_q[set_idx][miss_victim] && dirty_q[set_idx][miss_victim])
                               ? WB : FILL;
                end
            end
            WB: begin
                pmem_write    = 1'b1;
                pmem_addr_sel = 1'b1;
                way_sel       = victim_q;
                if (pmem_resp) begin
                    wb_done = 1'b1;
                    state_d = FILL;
                end
            end
            FILL: begin
                pmem_read = 1'b1;
                way_sel   = victim_q;
                if (pmem_resp) begin
                    data_we       = 1'b1;
                    data_sel_fill = 1'b1;
                    tag_we        = 1'b1;
                    fill_done     = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The set latched on a miss governs WB/FILL bookkeeping, not the live set_idx.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            victim_q <= 2'd0;
            set_q    <= '0;
            for (int i = 0; i < NUM_SETS; i++) begin
                plru_q[i]  <= 3'b000;
                valid_q[i] <= 4'b0000;
                dirty_q[i] <= 4'b0000;
            end
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            set_q    <= set_d;
            if (plru_upd)
                plru_q[set_idx] <= plru_touch(plru_q[set_idx], hit_w);
            if (dirty_hit)
                dirty_q[set_idx][hit_w] <= 1'b1;
            if (wb_done)
                dirty_q[set_q][victim_q] <= 1'b0;
            if (fill_done) begin
                valid_q[set_q][victim_q] <= 1'b1;
                dirty_q[set_q][victim_q] <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_plru_cache_ctrl.sv
// Randomized scoreboard bench for plru_cache_ctrl against a tree-of-pointers PLRU model.
module tb_plru_cache_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       mem_read, mem_write;
    logic [2:0] set_idx;
    logic [3:0] hit;
    logic [3:0] valid_out;
    logic       mem_resp;
    logic [1:0] way_sel;
    logic       data_we, data_sel_fill, tag_we, pmem_addr_sel;
    logic       pmem_read, pmem_write, pmem_resp;

    plru_cache_ctrl #(.S_BITS(3)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .set_idx(set_idx), .hit(hit), .valid_out(valid_out), .mem_resp(mem_resp),
        .way_sel(way_sel), .data_we(data_we), .data_sel_fill(data_sel_fill),
        .tag_we(tag_we), .pmem_addr_sel(pmem_addr_sel), .pmem_read(pmem_read),
        .pmem_write(pmem_write), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    int passes = 0;
    int total  = 0;
    bit abort  = 0;

    typedef struct {
        logic [1:0] way;
        logic       we;
        logic [3:0] vld;
    } exp_t;

    exp_t       resp_q[$];
    logic [1:0] wb_q[$];
    logic [1:0] fill_q[$];

    // Reference model: each set holds a root pointer (which half to replace)
    // and one pointer per half (which way inside that half to replace).
    bit [3:0] valid_m [8];
    bit [3:0] dirty_m [8];
    int       tag_m   [8][4];
    bit       root_right [8];
    int       lpick [8];
    int       rpick [8];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic void m_reset();
        for (int s = 0; s < 8; s++) begin
            valid_m[s] = '0; dirty_m[s] = '0;
            root_right[s] = 0; lpick[s] = 0; rpick[s] = 2'd0;
            for (int w = 0; w < 4; w++) tag_m[s][w] = -1;
        end
    endfunction

    function automatic int m_victim(input int s);
        for (int w = 0; w < 4; w++)
            if (!valid_m[s][w]) return w;
        return root_right[s] ? 2 + rpick[s] : lpick[s];
    endfunction

    function automatic void m_touch(input int s, input int w);
        root_right[s] = (w < 2);
        if (w < 2) lpick[s] = 1 - w;
        else       rpick[s] = 3 - w;
    endfunction

    // Monitor: pops expectations whenever the DUT presents a response or pmem completion.
    always @(negedge clk) begin
        if (!rst && mem_resp) begin
            if (resp_q.size() == 0) chk("unexpected_mem_resp", 1, 0);
            else begin
                exp_t e;
                e = resp_q.pop_front();
                chk("resp_way_sel", way_sel, e.way);
                chk("resp_data_we", data_we, e.we);
                chk("resp_data_sel_fill", data_sel_fill, 0);
                chk("resp_tag_we", tag_we, 0);
                chk("resp_valid_out", valid_out, e.vld);
                chk("resp_pmem_idle", {pmem_read, pmem_write}, 0);
            end
        end
        if (!rst && pmem_resp && pmem_write) begin
            if (wb_q.size() == 0) chk("unexpected_wb", 1, 0);
            else begin
                logic [1:0] w;
                w = wb_q.pop_front();
                chk("wb_way_sel", way_sel, w);
                chk("wb_addr_sel", pmem_addr_sel, 1);
                chk("wb_data_we", data_we, 0);
            end
        end
        if (!rst && pmem_resp && pmem_read) begin
            if (fill_q.size() == 0) chk("unexpected_fill", 1, 0);
            else begin
                logic [1:0] w;
                w = fill_q.pop_front();
                chk("fill_way_sel", way_sel, w);
                chk("fill_strobes", {data_we, data_sel_fill, tag_we, pmem_addr_sel}, 4'b1110);
            end
        end
    end

    task automatic do_txn(input int s, input int t, input int op);
        int       h, v, dly;
        bit       wr, miss, filled, was_read;
        bit [3:0] onehot, hv;
        exp_t     e;
        wr = (op != 0);
        h  = -1;
        for (int w = 0; w < 4; w++)
            if (valid_m[s][w] && tag_m[s][w] == t) h = w;
        miss = (h < 0);
        if (miss) begin
            v = m_victim(s);
            if (valid_m[s][v] && dirty_m[s][v]) wb_q.push_back(2'(v));
            fill_q.push_back(2'(v));
            valid_m[s][v] = 1'b1;
            dirty_m[s][v] = 1'b0;
            tag_m[s][v]   = t;
            h = v;
        end
        onehot = 4'b0001 << h;
        hv     = onehot | (4'($urandom) & valid_m[s] & (onehot - 4'd1));
        m_touch(s, h);
        if (wr) dirty_m[s][h] = 1'b1;
        e.way = 2'(h); e.we = wr; e.vld = valid_m[s];
        resp_q.push_back(e);

        mem_read  = (op != 1);
        mem_write = (op != 0);
        set_idx   = 3'(s);
        hit       = miss ? 4'b0000 : hv;
        if (miss) begin
            filled = 0; was_read = 0; dly = $urandom_range(0, 3);
            for (int c = 0; c < 60 && !filled; c++) begin
                @(posedge clk); #1;
                if (pmem_resp) begin
                    pmem_resp = 1'b0;
                    if (was_read) filled = 1;
                    dly = $urandom_range(0, 3);
                end else if (pmem_read || pmem_write) begin
                    if (dly == 0) begin
                        pmem_resp = 1'b1;
                        was_read  = pmem_read;
                    end else dly--;
                end
            end
            if (!filled) begin
                chk("miss_completion_timeout", 0, 1);
                abort = 1;
            end
            hit = hv;
        end
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0; hit = 4'b0000;
    endtask

    task automatic do_reset();
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; hit = 4'b0000; pmem_resp = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_reset();
    endtask

    initial begin
        set_idx = 3'd0;
        do_reset();
        @(negedge clk);
        chk("rst_mem_resp", mem_resp, 0);
        chk("rst_pmem", {pmem_read, pmem_write}, 0);
        chk("rst_writes", {data_we, tag_we}, 0);
        chk("rst_way_sel", way_sel, 0);
        for (int s = 0; s < 8; s++) begin
            set_idx = 3'(s);
            #1 chk("rst_valid_out", valid_out, 0);
        end
        @(posedge clk); #1;

        for (int i = 0; i < 400 && !abort; i++)
            do_txn($urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 2));

        if (!abort) begin
            // Fill set 0 with dirty lines so the next miss must write back, then reset mid-WB.
            do_reset();
            for (int t = 0; t < 4 && !abort; t++) do_txn(0, 100 + t, 1);
            mem_write = 1'b1; set_idx = 3'd0; hit = 4'b0000;
            for (int c = 0; c < 10 && !pmem_write; c++) begin
                @(posedge clk); #1;
            end
            chk("wb_entered", pmem_write, 1);
            chk("wb_way0", way_sel, 0);
            rst = 1'b1;
            @(posedge clk); #1;
            chk("rst_drops_pmem_write", pmem_write, 0);
            rst = 1'b0; mem_write = 1'b0;
            m_reset();
            for (int s = 0; s < 8; s++) begin
                set_idx = 3'(s);
                #1 chk("post_rst_valid_out", valid_out, 0);
            end
            @(posedge clk); #1;
            chk("post_rst_idle", {pmem_read, pmem_write, mem_resp}, 0);
        end

        repeat (3) @(posedge clk);
        chk("resp_q_drained", resp_q.size(), 0);
        chk("wb_q_drained", wb_q.size(), 0);
        chk("fill_q_drained", fill_q.size(), 0);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", passes, total);
        $fatal(1);
    end
endmodule
